// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter between core and loader onto one synchronous memory port
// One access at a time: IDLE grants, ACCESS issues a single mem_en beat then waits MEM_LAT cycles, DONE acks.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_C = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_cnt;
  logic              r_last_ld;
  logic              r_win_ld;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_grant;
  logic              w_grant_ld;
  logic              w_cap;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    w_grant_ld = ld_req;
    if (core_req && ld_req) begin
      w_grant_ld = ~r_last_ld;
    end
  end

  assign w_grant = (r_state == S_IDLE) && (core_req || ld_req);
  assign w_cap   = (r_state == S_ACCESS) && (r_cnt == LAT_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = w_grant ? S_ACCESS : S_IDLE;
      S_ACCESS: w_next = w_cap ? S_DONE : S_ACCESS;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 3'd0;
      r_last_ld <= 1'b1;
      r_win_ld  <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_grant) begin
        r_cnt     <= 3'd0;
        r_last_ld <= w_grant_ld;
        r_win_ld  <= w_grant_ld;
        r_we      <= w_grant_ld ? ld_we : core_we;
        r_addr    <= w_grant_ld ? ld_addr : core_addr;
        r_wdata   <= w_grant_ld ? ld_wdata : core_wdata;
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + 3'd1;
      end
      // Writes leave the last read data in place.
      if (w_cap && !r_we) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    core_ack = 1'b0;
    ld_ack   = 1'b0;
    case (r_state)
      S_ACCESS: mem_en = (r_cnt == 3'd0);
      S_DONE: begin
        core_ack = ~r_win_ld;
        ld_ack   = r_win_ld;
      end
      default: ;
    endcase
  end

  assign mem_we     = mem_en & r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign rdata      = r_rdata;
  assign core_stall = core_req & ~core_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=3
// Acks are matched against a scoreboard of expected {port, rdata} filled when each request is driven.
module tb_mem_port_arbiter;

  typedef struct {
    bit          ld;
    logic [31:0] rd;
  } exp_t;

  typedef struct {
    bit          ld;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req [2];
  logic        core_we [2];
  logic [31:0] core_addr [2];
  logic [31:0] core_wdata [2];
  logic        core_ack [2];
  logic        core_stall [2];
  logic        ld_req [2];
  logic        ld_we [2];
  logic [31:0] ld_addr [2];
  logic [31:0] ld_wdata [2];
  logic        ld_ack [2];
  logic [31:0] rdata [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];

  logic [31:0] shadow [2][64];
  logic [31:0] exp_rd [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h5EED0000 + 32'(i) * 32'h0101);
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [64];
    logic [31:0] pipe [8];
    logic [31:0] rd_w;
    exp_t        sb [$];
    int          junk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .core_req(core_req[g]), .core_we(core_we[g]), .core_addr(core_addr[g]),
      .core_wdata(core_wdata[g]), .core_ack(core_ack[g]), .core_stall(core_stall[g]),
      .ld_req(ld_req[g]), .ld_we(ld_we[g]), .ld_addr(ld_addr[g]),
      .ld_wdata(ld_wdata[g]), .ld_ack(ld_ack[g]),
      .rdata(rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(rd_w)
    );

    assign rd_w = pipe[LAT-1];

    initial begin
      junk = 0;
      for (int i = 0; i < 64; i++) mem[i] = init_val(i);
    end

    // Read data appears LAT cycles after the mem_en beat; every other slot carries junk.
    always @(posedge clk) begin
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][7:2]] : (32'hBAD00000 | 32'(junk));
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:2]] = mem_wdata[g];
      junk = junk + 1;
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
        chk("we_without_en", 32'(mem_we[g] & ~mem_en[g]), 32'd0);
        chk("stall", 32'(core_stall[g]), 32'(core_req[g] & ~core_ack[g]));
        chk("ack_overlap", 32'(core_ack[g] & ld_ack[g]), 32'd0);
        if (core_ack[g] || ld_ack[g]) begin
          chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ack_port", 32'(ld_ack[g]), 32'(e.ld));
            chk("rdata", rdata[g], e.rd);
          end
        end
      end
    end
  end

  task automatic push_exp(input int d, input bit ld, input bit we,
                          input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    if (we) shadow[d][addr[7:2]] = wd;
    else exp_rd[d] = shadow[d][addr[7:2]];
    e.ld = ld;
    e.rd = exp_rd[d];
    if (d == 0) g_dut[0].sb.push_back(e);
    else g_dut[1].sb.push_back(e);
  endtask

  task automatic drive(input int d, input bit ld, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (ld) begin
      ld_req[d] = req; ld_we[d] = we; ld_addr[d] = addr; ld_wdata[d] = wd;
    end else begin
      core_req[d] = req; core_we[d] = we; core_addr[d] = addr; core_wdata[d] = wd;
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE; that cycle is cycle 0.
  task automatic txn(input int d, input vec_t v);
    int L;
    int n_en;
    bit seen;
    L = lat_of(d);
    n_en = 0;
    seen = 0;
    push_exp(d, v.ld, v.we, v.addr, v.wd);
    drive(d, v.ld, 1'b1, v.we, v.addr, v.wd);
    for (int k = 0; k < 24 && !seen; k++) begin
      @(negedge clk);
      if (mem_en[d]) begin
        n_en++;
        chk("en_cycle", 32'(k), 32'd1);
        chk("en_we", 32'(mem_we[d]), 32'(v.we));
        if (v.we) chk("en_wdata", mem_wdata[d], v.wd);
      end
      if (k >= 1 && k <= L + 1) chk("addr_hold", mem_addr[d], v.addr);
      if (v.ld ? ld_ack[d] : core_ack[d]) begin
        seen = 1;
        chk("ack_cycle", 32'(k), 32'(L + 2));
        drive(d, v.ld, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("en_pulses", 32'(n_en), 32'd1);
  endtask

  vec_t vecs [9];
  int   nc;
  bit   fin;

  initial begin
    vecs[0] = '{ld: 0, we: 0, addr: 32'h10, wd: 32'h0};
    vecs[1] = '{ld: 1, we: 1, addr: 32'h40, wd: 32'h12345678};
    vecs[2] = '{ld: 0, we: 0, addr: 32'h40, wd: 32'h0};
    vecs[3] = '{ld: 1, we: 0, addr: 32'h08, wd: 32'h0};
    vecs[4] = '{ld: 0, we: 1, addr: 32'h20, wd: 32'hCAFEF00D};
    vecs[5] = '{ld: 1, we: 0, addr: 32'h20, wd: 32'h0};
    vecs[6] = '{ld: 0, we: 0, addr: 32'hFC, wd: 32'h0};
    vecs[7] = '{ld: 1, we: 1, addr: 32'h00, wd: 32'hFFFFFFFF};
    vecs[8] = '{ld: 0, we: 0, addr: 32'h00, wd: 32'h0};

    for (int d = 0; d < 2; d++) begin
      exp_rd[d] = 32'd0;
      for (int i = 0; i < 64; i++) shadow[d][i] = init_val(i);
      drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(d, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    end

    // Reset values
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rdata", rdata[d], 32'd0);
      chk("rst_mem_en", 32'(mem_en[d]), 32'd0);
      chk("rst_mem_we", 32'(mem_we[d]), 32'd0);
      chk("rst_mem_addr", mem_addr[d], 32'd0);
      chk("rst_acks", 32'({core_ack[d], ld_ack[d]}), 32'd0);
      chk("rst_stall", 32'(core_stall[d]), 32'd0);
    end

    // Both requesters high from reset release: core, loader, core.
    @(posedge clk); #1;
    push_exp(0, 1'b0, 1'b0, 32'h04, 32'd0);
    push_exp(0, 1'b1, 1'b0, 32'h08, 32'd0);
    push_exp(0, 1'b0, 1'b0, 32'h04, 32'd0);
    rst = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b0, 32'h04, 32'd0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h08, 32'd0);
    nc = 0;
    for (int k = 0; k < 20 && nc < 2; k++) begin
      @(negedge clk);
      if (ld_ack[0]) chk("rr_ld_cycle", 32'(k), 32'd7);
      if (core_ack[0]) begin
        chk(nc == 0 ? "rr_core1_cycle" : "rr_core2_cycle", 32'(k), nc == 0 ? 32'd3 : 32'd11);
        nc++;
        if (nc == 2) begin
          drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
          drive(0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
    end
    chk("rr_core_acks", 32'(nc), 32'd2);

    // Vector table on both latencies
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 9; i++) begin
        @(posedge clk); #1;
        txn(d, vecs[i]);
      end
    end

    // MEM_LAT=3: loader raises req while the core access is in flight.
    @(posedge clk); #1;
    push_exp(1, 1'b0, 1'b0, 32'h10, 32'd0);
    push_exp(1, 1'b1, 1'b0, 32'h30, 32'd0);
    drive(1, 1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    drive(1, 1'b1, 1'b0, 1'b0, 32'h30, 32'd0);
    fin = 0;
    for (int k = 0; k < 30 && !fin; k++) begin
      @(negedge clk);
      if (k == 2) ld_req[1] = 1'b1;
      if (k >= 1 && k <= 4) chk("mid_core_addr", mem_addr[1], 32'h10);
      if (k >= 7 && k <= 10) chk("mid_ld_addr", mem_addr[1], 32'h30);
      if (k == 7) chk("mid_ld_en", 32'(mem_en[1]), 32'd1);
      if (core_ack[1]) begin
        chk("mid_core_ack_cycle", 32'(k), 32'd5);
        core_req[1] = 1'b0;
      end
      if (ld_ack[1]) begin
        chk("mid_ld_ack_cycle", 32'(k), 32'd11);
        ld_req[1] = 1'b0;
        fin = 1;
      end
    end
    chk("mid_ld_done", 32'(fin), 32'd1);

    // Reset during ACCESS aborts the access without an ack.
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 1'b0, 32'h14, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_en", 32'(mem_en[0]), 32'd1);
    #1 rst = 1'b1;
    core_req[0] = 1'b0;
    #1;
    chk("abort_mem_en", 32'(mem_en[0]), 32'd0);
    chk("abort_acks", 32'({core_ack[0], ld_ack[0]}), 32'd0);
    chk("abort_rdata", rdata[0], 32'd0);
    chk("abort_rdata_other", rdata[1], 32'd0);
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'({core_ack[0], ld_ack[0]}), 32'd0);
    end
    @(posedge clk); #1;
    txn(0, '{ld: 0, we: 0, addr: 32'h14, wd: 32'h0});

    @(posedge clk); #1;
    chk("sb_drained0", 32'(g_dut[0].sb.size()), 32'd0);
    chk("sb_drained1", 32'(g_dut[1].sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
